counter_scheduler: RTL and testbench
====================================

// Module: counter_scheduler
// PURPOSE
//   Shares the dual event counter (fast Output0 via Slt=0, prescaled Output1 via Slt=1) among
//   NREQ requesters. Round-robin arbitration with req/ack handshake; serialises clear requests.
//   Drives the counter's En/Slt/Reset and mirrors its prescaler phase for software-visible status.
//   Sits between event sources and the counter instance, same clock domain.
// PARAMETERS
//   NREQ      4   number of requesters (>=2)
//   PRESCALE  4   Slt=1 events per Output1 increment; must equal counter's prescale (cnt==3 -> 4)
//   IDW       2   width of GrantId, = clog2(NREQ)
//   PW        4   width of SlowPhase, holds 0..PRESCALE-1
// PORTS
//   Clk        in   1     clock, rising edge
//   Reset      in   1     asynchronous, active-high reset
//   Req        in   NREQ  per-requester request; held until Ack[i] seen
//   ReqSlt     in   NREQ  per-requester counter select, stable while Req[i]=1
//   ClrReq     in   1     clear both counters; held until ClrAck seen
//   Hold       in   1     1 = issue no new grants or clears (in-flight op completes)
//   En         out  1     counter enable (registered)
//   Slt        out  1     counter select (registered)
//   CntClr     out  1     drives counter Reset (synchronous clear in counter)
//   Ack        out  NREQ  one-hot, 1-cycle grant acknowledge
//   ClrAck     out  1     1-cycle clear acknowledge
//   GrantId    out  IDW   index of last granted requester
//   Busy       out  1     1 while in ISSUE or CLEAR
//   SlowPhase  out  PW    mirror of counter prescaler phase
//   Tick1      out  1     1 in the cycle whose En causes an Output1 increment
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE, ptr=0; En,Slt,CntClr,Ack,ClrAck,GrantId,Busy,
//     SlowPhase,Tick1 all 0 immediately. Grant in flight is dropped: no Ack is ever issued for it.
//   - All outputs registered; decisions taken on the edge leaving IDLE.
//   - FSM IDLE: Hold=1 -> stay. Else ClrReq=1 -> CLEAR (clear beats requests). Else any Req ->
//     ISSUE with winner w = first set Req at index ptr, ptr+1, ... mod NREQ. Else stay.
//   - ISSUE (exactly 1 cycle): En=1, Slt=ReqSlt[w], Ack[w]=1, GrantId=w, Busy=1,
//     Tick1 = Slt & (SlowPhase==PRESCALE-1). On exit: ptr=(w+1) mod NREQ; if Slt=1 then
//     SlowPhase = (SlowPhase==PRESCALE-1) ? 0 : SlowPhase+1. Next state IDLE.
//   - CLEAR (exactly 1 cycle): CntClr=1, ClrAck=1, Busy=1, En=0. On exit SlowPhase=0, ptr unchanged.
//   - Outside ISSUE/CLEAR: En,Slt,CntClr,Ack,ClrAck,Tick1=0; GrantId holds.
//   - Throughput: max one grant per 2 cycles; requester sees Ack and drops Req on the next edge,
//     so the IDLE cycle after ISSUE never re-grants the same request.
//   - Requester re-asserting Req right after Ack is legal; it is a new request, ranked by ptr.
//   - Hold rising during ISSUE/CLEAR: that op completes; FSM then parks in IDLE.
//   - Req[i] with no further grant while others request: served within NREQ grants (starvation-free).
//   - SlowPhase only changes on Slt=1 grants and CLEAR; Slt=0 grants leave it untouched.
// TESTING
//   1 Reset, Req=0001,ReqSlt=0 -> cycle2 En=1,Slt=0,Ack=0001,GrantId=0; counter Output0=1.
//   2 Req=1111 held, each dropped after its Ack -> grant order 0,1,2,3 on cycles 2,4,6,8; never back-to-back.
//   3 Requester 2, ReqSlt=1, 8 grants -> Tick1 on grants 4 and 8; SlowPhase 1,2,3,0,1,2,3,0; Output1=2.
//   4 ClrReq and Req=0010 same cycle -> CLEAR first (CntClr,ClrAck=1, SlowPhase=0), grant 1 two cycles later.
//   5 Hold=1 with Req=0011 for 10 cycles -> En and Ack stay 0; Hold=0 -> grant to ptr's requester next.
//   6 Reset asserted mid-ISSUE -> En,Ack,Busy fall immediately; after release ptr=0, requester 0 wins first.

Source files
------------

// File: rtl/counter_scheduler.sv
// Round-robin scheduler sharing one dual event counter among NREQ requesters.
// Grants and clears are one-cycle operations; all outputs are registered.
module counter_scheduler #(
    parameter int NREQ     = 4,
    parameter int PRESCALE = 4,
    parameter int IDW      = 2,
    parameter int PW       = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic [NREQ-1:0] req_slt_i,
    input  logic            clr_req_i,
    input  logic            hold_i,
    output logic            en_o,
    output logic            slt_o,
    output logic            cnt_clr_o,
    output logic [NREQ-1:0] ack_o,
    output logic            clr_ack_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            busy_o,
    output logic [PW-1:0]   slow_phase_o,
    output logic            tick1_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic            en_q, en_d;
    logic            slt_q, slt_d;
    logic            clr_q, clr_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            clr_ack_q, clr_ack_d;
    logic            busy_q, busy_d;
    logic            tick_q, tick_d;

    logic [IDW-1:0]  win;
    logic [IDW-1:0]  idx_v;
    logic            any_req;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win     = '0;
        idx_v   = '0;
        any_req = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_v = IDW'((int'(ptr_q) + k) % NREQ);
            if (req_i[idx_v]) begin
                win     = idx_v;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = S_IDLE;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        grant_d   = grant_q;
        en_d      = 1'b0;
        slt_d     = 1'b0;
        clr_d     = 1'b0;
        ack_d     = '0;
        clr_ack_d = 1'b0;
        busy_d    = 1'b0;
        tick_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hold_i) begin
                    if (clr_req_i) begin
                        state_d   = S_CLEAR;
                        clr_d     = 1'b1;
                        clr_ack_d = 1'b1;
                        busy_d    = 1'b1;
                    end else if (any_req) begin
                        state_d    = S_ISSUE;
                        en_d       = 1'b1;
                        slt_d      = req_slt_i[win];
                        ack_d[win] = 1'b1;
                        grant_d    = win;
                        busy_d     = 1'b1;
                        tick_d     = req_slt_i[win] && (phase_q == PW'(PRESCALE - 1));
                    end
                end
            end
            S_ISSUE: begin
                // Pointer and prescaler mirror advance on the edge leaving ISSUE.
                ptr_d = IDW'((int'(grant_q) + 1) % NREQ);
                if (slt_q) begin
                    phase_d = (phase_q == PW'(PRESCALE - 1)) ? '0 : phase_q + PW'(1);
                end
            end
            S_CLEAR: begin
                phase_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            phase_q   <= '0;
            grant_q   <= '0;
            en_q      <= 1'b0;
            slt_q     <= 1'b0;
            clr_q     <= 1'b0;
            ack_q     <= '0;
            clr_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            phase_q   <= phase_d;
            grant_q   <= grant_d;
            en_q      <= en_d;
            slt_q     <= slt_d;
            clr_q     <= clr_d;
            ack_q     <= ack_d;
            clr_ack_q <= clr_ack_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
        end
    end

    assign en_o         = en_q;
    assign slt_o        = slt_q;
    assign cnt_clr_o    = clr_q;
    assign ack_o        = ack_q;
    assign clr_ack_o    = clr_ack_q;
    assign grant_id_o   = grant_q;
    assign busy_o       = busy_q;
    assign slow_phase_o = phase_q;
    assign tick1_o      = tick_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: grant order, prescaler mirror, clear priority,
// hold and mid-operation reset, with hand-computed expectations.
module tb_counter_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] req_slt;
    logic       clr_req;
    logic       hold;
    logic       en;
    logic       slt;
    logic       cnt_clr;
    logic [3:0] ack;
    logic       clr_ack;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] slow_phase;
    logic       tick1;

    int total = 0;
    int bad   = 0;

    counter_scheduler #(
        .NREQ(4), .PRESCALE(4), .IDW(2), .PW(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_slt_i    (req_slt),
        .clr_req_i    (clr_req),
        .hold_i       (hold),
        .en_o         (en),
        .slt_o        (slt),
        .cnt_clr_o    (cnt_clr),
        .ack_o        (ack),
        .clr_ack_o    (clr_ack),
        .grant_id_o   (grant_id),
        .busy_o       (busy),
        .slow_phase_o (slow_phase),
        .tick1_o      (tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_slt = '0;
        clr_req = 1'b0;
        hold    = 1'b0;

        // Test 1: reset state, then a single fast grant
        step();
        step();
        chk("rst_en",    32'(en), 32'd0);
        chk("rst_ack",   32'(ack), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_phase", 32'(slow_phase), 32'd0);
        chk("rst_gid",   32'(grant_id), 32'd0);
        rst = 1'b0;
        req = 4'b0001;
        step();
        chk("t1_en",   32'(en), 32'd1);
        chk("t1_slt",  32'(slt), 32'd0);
        chk("t1_ack",  32'(ack), 32'b0001);
        chk("t1_gid",  32'(grant_id), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        $display("t1 grant id=%0d ack=%b", grant_id, ack);
        req = 4'b0000;
        step();
        chk("t1_idle_en",   32'(en), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Test 2: all four requesting, round-robin order 0..3, never back-to-back
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            step();
            chk("t2_ack", 32'(ack), 32'(4'b0001 << g));
            chk("t2_gid", 32'(grant_id), 32'(g));
            chk("t2_en",  32'(en), 32'd1);
            $display("t2 grant id=%0d ack=%b", grant_id, ack);
            req[g] = 1'b0;
            step();
            chk("t2_gap_en", 32'(en), 32'd0);
        end

        // Test 3: requester 2 on slow counter, 8 grants
        for (int g = 1; g <= 8; g++) begin
            req[2]     = 1'b1;
            req_slt[2] = 1'b1;
            step();
            chk("t3_ack",  32'(ack), 32'b0100);
            chk("t3_slt",  32'(slt), 32'd1);
            chk("t3_tick", 32'(tick1), 32'((g % 4) == 0));
            $display("t3 grant %0d id=%0d tick1=%0d phase=%0d", g, grant_id, tick1, slow_phase);
            req[2] = 1'b0;
            step();
            chk("t3_phase", 32'(slow_phase), 32'(g % 4));
        end
        req_slt = '0;

        // Test 4: slow grant, fast grant leaves phase, then clear beats a request
        req     = 4'b1000;
        req_slt = 4'b1000;
        step();
        chk("t4_ack3", 32'(ack), 32'b1000);
        req     = 4'b0000;
        req_slt = 4'b0000;
        step();
        chk("t4_phase1", 32'(slow_phase), 32'd1);
        req = 4'b0001;
        step();
        chk("t4_ack0",   32'(ack), 32'b0001);
        chk("t4_tick0",  32'(tick1), 32'd0);
        req = 4'b0000;
        step();
        chk("t4_phase_keep", 32'(slow_phase), 32'd1);
        clr_req = 1'b1;
        req     = 4'b0010;
        step();
        chk("t4_cntclr", 32'(cnt_clr), 32'd1);
        chk("t4_clrack", 32'(clr_ack), 32'd1);
        chk("t4_clr_en", 32'(en), 32'd0);
        chk("t4_clr_ack_req", 32'(ack), 32'd0);
        chk("t4_clr_busy", 32'(busy), 32'd1);
        $display("t4 clear cntclr=%0d clrack=%0d", cnt_clr, clr_ack);
        clr_req = 1'b0;
        step();
        chk("t4_phase0", 32'(slow_phase), 32'd0);
        chk("t4_gap_en", 32'(en), 32'd0);
        chk("t4_gap_cntclr", 32'(cnt_clr), 32'd0);
        step();
        chk("t4_ack1", 32'(ack), 32'b0010);
        chk("t4_gid1", 32'(grant_id), 32'd1);
        $display("t4 grant id=%0d ack=%b", grant_id, ack);
        req = 4'b0000;
        step();

        // Test 5: hold blocks grants; release grants from ptr=2 -> requester 0 then 1
        hold = 1'b1;
        req  = 4'b0011;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t5_hold_en",  32'(en), 32'd0);
            chk("t5_hold_ack", 32'(ack), 32'd0);
        end
        hold = 1'b0;
        step();
        chk("t5_ack0", 32'(ack), 32'b0001);
        chk("t5_gid0", 32'(grant_id), 32'd0);
        $display("t5 grant id=%0d ack=%b", grant_id, ack);
        req[0] = 1'b0;
        step();
        step();
        chk("t5_ack1", 32'(ack), 32'b0010);
        $display("t5 grant id=%0d ack=%b", grant_id, ack);
        req[1] = 1'b0;
        step();

        // Test 6: reset mid-ISSUE drops the grant and returns ptr to 0
        req = 4'b0100;
        step();
        chk("t6_issue_en", 32'(en), 32'd1);
        chk("t6_issue_gid", 32'(grant_id), 32'd2);
        #2;
        rst = 1'b1;
        req = 4'b0101;
        #1;
        chk("t6_rst_en",   32'(en), 32'd0);
        chk("t6_rst_ack",  32'(ack), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_gid",  32'(grant_id), 32'd0);
        #2;
        rst = 1'b0;
        step();
        chk("t6_first_ack", 32'(ack), 32'b0001);
        $display("t6 grant id=%0d ack=%b", grant_id, ack);
        req[0] = 1'b0;
        step();
        step();
        chk("t6_second_ack", 32'(ack), 32'b0100);
        $display("t6 grant id=%0d ack=%b", grant_id, ack);
        req = 4'b0000;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
